pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Combines data-cache stalls, load-use hazards and ID-stage branch redirects into one prioritised set of enables. These enables drive the PC register, the IF/ID register (write and flush), the ID/EX bubble insert and the global stage-freeze line. The block also keeps a pending-flush latch across memory stalls, a stall watchdog and three performance counters.

## Interface
- TIMEOUT, default 1024: max consecutive mem_stall_i cycles before err_o sets; legal range 2..65535.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- mem_stall_i  input  1  data cache busy; whole pipeline must freeze.
- ID_rs1_i  input  5  rs1 of instruction in ID.
- ID_rs2_i  input  5  rs2 of instruction in ID.
- EX_rd_i  input  5  rd of instruction in EX.
- EX_MemRead_i  input  1  instruction in EX is a load.
- branch_taken_i  input  1  ID resolved a taken branch/jump this cycle.
- PC_Write_o  output  1  PC register load enable.
- IFID_Write_o  output  1  IF/ID load enable.
- IFID_Flush_o  output  1  IF/ID clear to zero.
- IDEX_NoOp_o  output  1  ID/EX loads a bubble (control bits 0).
- pipe_stall_o  output  1  freeze ID/EX, EX/MEM, MEM/WB.
- err_o  output  1  sticky watchdog error.
- stall_cnt_o  output  32  cycles spent in memory stall.
- bubble_cnt_o  output  32  load-use bubbles inserted.
- flush_cnt_o  output  32  IF/ID flushes issued.

## Operation
- State: RUN, MEM_WAIT. Extra registers: flush_pend (1 b), wd_cnt (16 b), err, and three counters.
- load_use = EX_MemRead_i & (EX_rd_i != 0) & (EX_rd_i == ID_rs1_i | EX_rd_i == ID_rs2_i).
- Priority, highest first: reset, mem stall, load-use, flush, normal.
- Mem stall (mem_stall_i=1, either state):
  - Outputs: PC_Write_o=0, IFID_Write_o=0, IFID_Flush_o=0, IDEX_NoOp_o=0, pipe_stall_o=1.
  - Next state is MEM_WAIT.
  - If branch_taken_i=1, flush_pend is set.
  - stall_cnt_o increments.
- Load-use (no mem stall, load_use=1):
  - Outputs: PC_Write_o=0, IFID_Write_o=0, IDEX_NoOp_o=1, pipe_stall_o=0, IFID_Flush_o=0.
  - branch_taken_i and flush_pend are ignored this cycle; flush_pend is held.
  - bubble_cnt_o increments. Next state is RUN.
- Flush (no stall, no load_use, branch_taken_i | flush_pend):
  - Outputs: PC_Write_o=1, IFID_Write_o=1, IFID_Flush_o=1, IDEX_NoOp_o=0.
  - flush_pend clears. flush_cnt_o increments by 1 even if both sources are set.
- Normal: PC_Write_o=1, IFID_Write_o=1, all other outputs 0.
- Leaving MEM_WAIT: the first cycle with mem_stall_i=0 is evaluated with the RUN rules (load-use/flush/normal), and the state returns to RUN.
- Watchdog:
  - wd_cnt increments each mem_stall_i cycle, saturating at TIMEOUT, and clears when mem_stall_i=0.
  - err_o sets when wd_cnt reaches TIMEOUT and stays set until rst_i. Pipeline behaviour is unchanged.
- Counters are 32-bit and wrap 0xFFFFFFFF→0.
- Outputs are combinational from current inputs plus state; only state, flush_pend, wd_cnt, err and the counters are registered.

## Timing
- Zero-cycle decision: enables are valid in the same cycle as the inputs, for consumption at the next edge.
- Reset, while rst_i=1:
  - Outputs forced: PC_Write_o=0, IFID_Write_o=0, IFID_Flush_o=0, IDEX_NoOp_o=0, pipe_stall_o=0.
  - At the edge: state=RUN, flush_pend=0, wd_cnt=0, err_o=0, all counters=0.
- Reset mid-MEM_WAIT discards flush_pend.
- A load-use bubble lasts exactly 1 cycle unless extended by a mem stall.
- A flush deferred by a stall is issued on the first non-stall, non-load-use cycle after the stall ends.
- Counter values are visible the cycle after the event.

## Structure
- pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT};
  - TIMEOUT default;
  - counter width constant (32).
- Sub-module load_use_detect: combinational comparator (rs1, rs2, rd, MemRead → load_use), reused by the forwarding unit tests.

## Test plan
- Reset release, no hazards, 5 cycles → PC_Write_o=IFID_Write_o=1 every cycle; all counters 0.
- EX_MemRead_i=1, EX_rd_i=5, ID_rs2_i=5 for one cycle → PC_Write_o=0, IDEX_NoOp_o=1 in that cycle; bubble_cnt_o=1 next cycle. Repeat with EX_rd_i=0 → no bubble.
- mem_stall_i high 3 cycles with branch_taken_i pulsed in cycle 2 → pipe_stall_o=1 for 3 cycles; cycle 4 has IFID_Flush_o=1 and PC_Write_o=1; stall_cnt_o=3, flush_cnt_o=1.
- Stall end coincides with load_use=1 and flush_pend=1 → bubble first, flush on the following cycle; flush_cnt_o=1.
- TIMEOUT=4, mem_stall_i held 6 cycles → err_o rises after the 4th stall cycle and stays 1 after the stall ends until rst_i.
- rst_i asserted mid-MEM_WAIT with flush_pend=1 → after reset, no flush issued; state RUN, err_o=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller.
//            Holds the sequencer state encoding, the default watchdog limit
//            and the counter / watchdog widths.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Sequencer state: running normally, or held by a data-cache stall.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int TIMEOUT_DEFAULT = 1024;  // max consecutive stall cycles
    localparam int CNT_W           = 32;    // performance counter width
    localparam int WD_W            = 16;    // watchdog counter width

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Purpose  : Combinational load-use hazard comparator. Flags when the load
//            in EX writes a non-zero register that the instruction in ID
//            reads.
// Ports    : rs1_i, rs2_i    - source registers of the ID instruction
//            rd_i            - destination register of the EX instruction
//            mem_read_i      - EX instruction is a load
//            load_use_o      - hazard detected
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect (
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    input  logic       mem_read_i,
    output logic       load_use_o
);

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use_o = mem_read_i
                      & (rd_i != 5'd0)
                      & ((rd_i == rs1_i) | (rd_i == rs2_i));

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Central stall/flush sequencer for the 5-stage pipeline. Merges
//            data-cache stalls, load-use hazards and ID-stage redirects into
//            one prioritised set of enables; keeps a pending-flush latch
//            across memory stalls, a stall watchdog and perf counters.
// Ports    : clk_i, rst_i             - clock, synchronous active-high reset
//            mem_stall_i              - data cache busy
//            ID_rs1_i, ID_rs2_i       - ID source registers
//            EX_rd_i, EX_MemRead_i    - EX destination / load flag
//            branch_taken_i           - ID redirect this cycle
//            PC_Write_o, IFID_Write_o - PC and IF/ID load enables
//            IFID_Flush_o             - IF/ID clear
//            IDEX_NoOp_o              - ID/EX bubble insert
//            pipe_stall_o             - freeze ID/EX, EX/MEM, MEM/WB
//            err_o                    - sticky watchdog error
//            stall_cnt_o, bubble_cnt_o, flush_cnt_o - perf counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_stall_i,
    input  logic [4:0]       ID_rs1_i,
    input  logic [4:0]       ID_rs2_i,
    input  logic [4:0]       EX_rd_i,
    input  logic             EX_MemRead_i,
    input  logic             branch_taken_i,
    output logic             PC_Write_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_NoOp_o,
    output logic             pipe_stall_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [WD_W-1:0]  c_WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  c_WD_ONE  = WD_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_e            state_q, state_d;
    logic              flush_pend_q, flush_pend_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              w_load_use;

    load_use_detect u_load_use_detect (
        .rs1_i      (ID_rs1_i),
        .rs2_i      (ID_rs2_i),
        .rd_i       (EX_rd_i),
        .mem_read_i (EX_MemRead_i),
        .load_use_o (w_load_use)
    );

    always_comb begin
        state_d       = state_q;
        flush_pend_d  = flush_pend_q;
        wd_cnt_d      = wd_cnt_q;
        err_d         = err_q;
        stall_cnt_d   = stall_cnt_q;
        bubble_cnt_d  = bubble_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        PC_Write_o    = 1'b0;
        IFID_Write_o  = 1'b0;
        IFID_Flush_o  = 1'b0;
        IDEX_NoOp_o   = 1'b0;
        pipe_stall_o  = 1'b0;

        case (state_q)
            RUN:      if (mem_stall_i)  state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_stall_i) state_d = RUN;
        endcase

        if (mem_stall_i) begin
            pipe_stall_o = 1'b1;
            stall_cnt_d  = stall_cnt_q + c_CNT_ONE;
            // A redirect seen while frozen cannot flush IF/ID yet; remember it.
            if (branch_taken_i) flush_pend_d = 1'b1;
            wd_cnt_d = (wd_cnt_q == c_WD_MAX) ? wd_cnt_q : wd_cnt_q + c_WD_ONE;
            if (wd_cnt_d == c_WD_MAX) err_d = 1'b1;
        end else begin
            wd_cnt_d = '0;
            if (w_load_use) begin
                // Bubble wins over a redirect; the pending flush is held and
                // a redirect arriving this cycle is dropped.
                IDEX_NoOp_o  = 1'b1;
                bubble_cnt_d = bubble_cnt_q + c_CNT_ONE;
            end else begin
                PC_Write_o   = 1'b1;
                IFID_Write_o = 1'b1;
                if (branch_taken_i || flush_pend_q) begin
                    IFID_Flush_o = 1'b1;
                    flush_pend_d = 1'b0;
                    flush_cnt_d  = flush_cnt_q + c_CNT_ONE;
                end
            end
        end

        // Reset holds every enable low regardless of the other inputs.
        if (rst_i) begin
            PC_Write_o   = 1'b0;
            IFID_Write_o = 1'b0;
            IFID_Flush_o = 1'b0;
            IDEX_NoOp_o  = 1'b0;
            pipe_stall_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
            wd_cnt_q     <= '0;
            err_q        <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            wd_cnt_q     <= wd_cnt_d;
            err_q        <= err_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign err_o        = err_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. Directed scenarios
//            followed by random traffic, compared every cycle against a
//            behavioural model of the prioritised stall/flush rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, mem_stall, memrd, br;
    logic [4:0]  rs1, rs2, rd;
    logic        pc_w, ifid_w, ifid_f, noop, pstall, err;
    logic [31:0] stall_cnt, bubble_cnt, flush_cnt;

    // Reference model state
    bit          m_pend, m_err;
    int          m_wd;
    logic [31:0] m_stall, m_bub, m_flush;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mem_stall_i    (mem_stall),
        .ID_rs1_i       (rs1),
        .ID_rs2_i       (rs2),
        .EX_rd_i        (rd),
        .EX_MemRead_i   (memrd),
        .branch_taken_i (br),
        .PC_Write_o     (pc_w),
        .IFID_Write_o   (ifid_w),
        .IFID_Flush_o   (ifid_f),
        .IDEX_NoOp_o    (noop),
        .pipe_stall_o   (pstall),
        .err_o          (err),
        .stall_cnt_o    (stall_cnt),
        .bubble_cnt_o   (bubble_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    endtask

    // One cycle: apply inputs, check outputs against the model, clock, update model.
    task automatic step(input bit r, input bit s, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input bit m, input bit t);
        bit lu, e_pc, e_ifw, e_fl, e_nop, e_st;
        @(negedge clk);
        rst = r; mem_stall = s; rs1 = a; rs2 = b; rd = d; memrd = m; br = t;
        #1;
        lu = m && (d != 0) && (d == a || d == b);
        {e_pc, e_ifw, e_fl, e_nop, e_st} = '0;
        if (r)                 ;
        else if (s)            e_st = 1;
        else if (lu)           e_nop = 1;
        else if (t || m_pend)  {e_pc, e_ifw, e_fl} = 3'b111;
        else                   {e_pc, e_ifw} = 2'b11;
        chk("PC_Write",   32'(pc_w),   32'(e_pc));
        chk("IFID_Write", 32'(ifid_w), 32'(e_ifw));
        chk("IFID_Flush", 32'(ifid_f), 32'(e_fl));
        chk("IDEX_NoOp",  32'(noop),   32'(e_nop));
        chk("pipe_stall", 32'(pstall), 32'(e_st));
        chk("err",        32'(err),    32'(m_err));
        chk("stall_cnt",  stall_cnt,   m_stall);
        chk("bubble_cnt", bubble_cnt,  m_bub);
        chk("flush_cnt",  flush_cnt,   m_flush);
        @(posedge clk);
        if (r) begin
            m_pend = 0; m_err = 0; m_wd = 0; m_stall = 0; m_bub = 0; m_flush = 0;
        end else if (s) begin
            m_stall++;
            if (t) m_pend = 1;
            m_wd = (m_wd + 1 > TO) ? TO : m_wd + 1;
            if (m_wd == TO) m_err = 1;
        end else begin
            m_wd = 0;
            if (lu) m_bub++;
            else if (t || m_pend) begin m_flush++; m_pend = 0; end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 5'd1, 5'd2, 5'd3, 0, 0);
    endtask

    int burst = 0;

    initial begin
        m_pend = 0; m_err = 0; m_wd = 0; m_stall = 0; m_bub = 0; m_flush = 0;
        rst = 1; mem_stall = 0; rs1 = 0; rs2 = 0; rd = 0; memrd = 0; br = 0;

        // Reset, then five hazard-free cycles
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 5, 5, 1, 1);
        idle(5);

        // Load-use on rs2, then the same with rd = x0
        step(0, 0, 5'd1, 5'd5, 5'd5, 1, 0);
        idle(1);
        step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
        idle(1);

        // Three-cycle stall with a redirect in the middle; flush after it
        step(0, 1, 1, 2, 3, 0, 0);
        step(0, 1, 1, 2, 3, 0, 1);
        step(0, 1, 1, 2, 3, 0, 0);
        idle(2);

        // Stall ends on a load-use with a pending flush: bubble, then flush
        step(0, 1, 1, 2, 3, 0, 1);
        step(0, 0, 5'd7, 5'd2, 5'd7, 1, 0);
        idle(2);

        // Watchdog: six stall cycles, err stays after the stall ends
        for (int i = 0; i < 6; i++) step(0, 1, 1, 2, 3, 0, 0);
        idle(3);

        // Reset in the middle of a stall with a pending flush
        step(0, 1, 1, 2, 3, 0, 1);
        step(1, 1, 1, 2, 3, 0, 0);
        idle(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit s;
            if (burst == 0 && $urandom_range(0, 7) == 0) burst = $urandom_range(1, 7);
            s = (burst > 0);
            if (burst > 0) burst--;
            step($urandom_range(0, 63) == 0, s,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
